// File: rtl/ysyx22041405_lsu_pkg.sv
// ysyx22041405_lsu_pkg
//   Shared definitions for the load/store stage: bundle width macros,
//   mem_op bit positions, access-size codes, FSM states and the packed
//   layouts of the EX->LS and LS->WB bundles.
//   Optional feature macro (consumed by the top): YSYX22041405_LSU_MISALIGN_CHK_EN.

`ifndef YSYX22041405_LSU_DEFS
`define YSYX22041405_LSU_DEFS
// {pc, inst, rf_waddr, alu_res, st_data, mem_op, rf_we, inst_ebreak, inst_valid}
`define EX_LS_WIDTH   140
// {rf_waddr, rf_wdata, dm_rdata_aligned, pc, inst}
`define LS_DATA_WIDTH 133
// {inst_ebreak, inst_valid, rf_we, rmask[7:0]}
`define LS_CTRL_WIDTH 11
`define LS_WB_WIDTH   (`LS_DATA_WIDTH + `LS_CTRL_WIDTH)
`endif

package ysyx22041405_lsu_pkg;

   localparam int unsigned LS_XLEN = 32;

   // mem_op bit positions
   localparam int unsigned MEM_OP_IS_MEM   = 3;
   localparam int unsigned MEM_OP_IS_STORE = 2;

   typedef enum logic [1:0] {
      SIZE_B = 2'b00,
      SIZE_H = 2'b01,
      SIZE_W = 2'b10
   } ls_size_e;

   typedef enum logic [1:0] {
      LS_IDLE = 2'd0,
      LS_REQ  = 2'd1,
      LS_WAIT = 2'd2,
      LS_OUT  = 2'd3
   } ls_state_e;

   typedef struct packed {
      logic [31:0]        pc;
      logic [31:0]        inst;
      logic [4:0]         rf_waddr;
      logic [LS_XLEN-1:0] alu_res;
      logic [LS_XLEN-1:0] st_data;
      logic [3:0]         mem_op;
      logic               rf_we;
      logic               inst_ebreak;
      logic               inst_valid;
   } ex_ls_t;

   typedef struct packed {
      logic [4:0]         rf_waddr;
      logic [LS_XLEN-1:0] rf_wdata;
      logic [LS_XLEN-1:0] dm_rdata_aligned;
      logic [31:0]        pc;
      logic [31:0]        inst;
      logic               inst_ebreak;
      logic               inst_valid;
      logic               rf_we;
      logic [7:0]         rmask;
   } ls_wb_t;

   // Half needs 2-byte alignment, word (and the unused size 11) 4-byte.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SIZE_B:  is_misaligned = 1'b0;
         SIZE_H:  is_misaligned = off[0];
         default: is_misaligned = (off != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/ysyx22041405_lsu_align.sv
// ysyx22041405_lsu_align
//   Combinational byte-lane logic for the load/store stage.
//   Ports:
//     size        in  2      access size (00 byte, 01 half, 10 word)
//     off         in  2      address bits [1:0]
//     is_unsigned in  1      zero-extend loads when set
//     st_data     in  WIDTH  store data, right-justified
//     rdata       in  WIDTH  raw memory word
//     wdata       out WIDTH  store data moved to its byte lane
//     mask        out 8      byte mask, bits [7:4] always 0
//     rvalue      out WIDTH  extracted and extended load value
//   Lanes shifted past byte 3 fall off the word (no wrap).

module ysyx22041405_lsu_align
   import ysyx22041405_lsu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [1:0]       size,
   input  logic [1:0]       off,
   input  logic             is_unsigned,
   input  logic [WIDTH-1:0] st_data,
   input  logic [WIDTH-1:0] rdata,
   output logic [WIDTH-1:0] wdata,
   output logic [7:0]       mask,
   output logic [WIDTH-1:0] rvalue
);

   logic [3:0]       lane_base;
   logic [3:0]       lane;
   logic [4:0]       sh_amt;
   logic [WIDTH-1:0] shifted;

   always_comb begin
      lane_base = 4'b1111;
      case (size)
         SIZE_B:  lane_base = 4'b0001;
         SIZE_H:  lane_base = 4'b0011;
         default: lane_base = 4'b1111;
      endcase
      sh_amt  = {off, 3'b000};
      lane    = lane_base << off;
      mask    = {4'b0000, lane};
      wdata   = st_data << sh_amt;
      shifted = rdata >> sh_amt;
      case (size)
         SIZE_B:  rvalue = {{(WIDTH-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
         SIZE_H:  rvalue = {{(WIDTH-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
         default: rvalue = shifted;
      endcase
   end

endmodule

// File: rtl/ysyx22041405_lsu.sv
// ysyx22041405_lsu
//   Load/store stage: takes one EX bundle, performs at most one data-memory
//   transaction (req/gnt then rvalid), aligns/extends load data and holds a
//   registered LS->WB bundle until writeback accepts it.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     ex_ls_valid/ready/message   EX->LS handshake and bundle (`EX_LS_WIDTH)
//     dm_req/we/addr/wdata/wmask  memory request, driven only while in REQ
//     dm_gnt                      request accepted this cycle
//     dm_rvalid/dm_rdata          load response
//     ls_wb_valid/ready           LS->WB handshake
//     LS_WB_message               registered LS->WB bundle (`LS_WB_WIDTH)
//   Optional: define YSYX22041405_LSU_MISALIGN_CHK_EN to turn misaligned
//   half/word accesses into a no-request bubble with inst_valid=0, rf_we=0.

module ysyx22041405_lsu
   import ysyx22041405_lsu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ex_ls_valid,
   output logic                     ex_ls_ready,
   input  logic [`EX_LS_WIDTH-1:0]  ex_ls_message,
   output logic                     dm_req,
   output logic                     dm_we,
   output logic [31:0]              dm_addr,
   output logic [WIDTH-1:0]         dm_wdata,
   output logic [7:0]               dm_wmask,
   input  logic                     dm_gnt,
   input  logic                     dm_rvalid,
   input  logic [WIDTH-1:0]         dm_rdata,
   output logic                     ls_wb_valid,
   input  logic                     ls_wb_ready,
   output logic [`LS_WB_WIDTH-1:0]  LS_WB_message
);

   ls_state_e  state, state_nxt;
   ex_ls_t     in_b, bundle_q, cur_b;
   ls_wb_t     msg_d, msg_q;

   logic             is_mem, is_store, misaligned, load_done, in_req;
   logic [1:0]       size, off;
   logic [WIDTH-1:0] al_wdata, al_rvalue;
   logic [7:0]       al_mask;

   assign in_b = ex_ls_t'(ex_ls_message);

   // In IDLE the incoming bundle is decoded directly so non-memory and
   // rejected accesses can reach OUT in a single cycle.
   assign cur_b    = (state == LS_IDLE) ? in_b : bundle_q;
   assign is_mem   = cur_b.mem_op[MEM_OP_IS_MEM];
   assign is_store = cur_b.mem_op[MEM_OP_IS_STORE];
   assign size     = cur_b.mem_op[1:0];
   assign off      = cur_b.alu_res[1:0];

`ifdef YSYX22041405_LSU_MISALIGN_CHK_EN
   assign misaligned = is_mem & is_misaligned(size, off);
`else
   assign misaligned = 1'b0;
`endif

   ysyx22041405_lsu_align #(.WIDTH(WIDTH)) u_align (
      .size        (size),
      .off         (off),
      .is_unsigned (cur_b.inst[14]),
      .st_data     (cur_b.st_data),
      .rdata       (dm_rdata),
      .wdata       (al_wdata),
      .mask        (al_mask),
      .rvalue      (al_rvalue)
   );

   // Load data arrives either in WAIT or together with the grant in REQ.
   assign load_done = ~is_store & dm_rvalid &
                      ((state == LS_WAIT) || ((state == LS_REQ) && dm_gnt));

   always_ff @(posedge clk) begin
      if (rst) state <= LS_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         LS_IDLE: if (ex_ls_valid) state_nxt = (is_mem && !misaligned) ? LS_REQ : LS_OUT;
         LS_REQ:  if (dm_gnt)      state_nxt = (is_store || dm_rvalid) ? LS_OUT : LS_WAIT;
         LS_WAIT: if (dm_rvalid)   state_nxt = LS_OUT;
         LS_OUT:  if (ls_wb_ready) state_nxt = LS_IDLE;
         default:                  state_nxt = LS_IDLE;
      endcase
   end

   always_comb begin
      msg_d                  = '0;
      msg_d.rf_waddr         = cur_b.rf_waddr;
      msg_d.rf_wdata         = load_done ? al_rvalue : cur_b.alu_res;
      msg_d.dm_rdata_aligned = load_done ? al_rvalue : '0;
      msg_d.pc               = cur_b.pc;
      msg_d.inst             = cur_b.inst;
      msg_d.inst_ebreak      = cur_b.inst_ebreak;
      msg_d.inst_valid       = cur_b.inst_valid & ~misaligned;
      msg_d.rf_we            = cur_b.rf_we & ~misaligned;
      msg_d.rmask            = load_done ? al_mask : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bundle_q <= '0;
         msg_q    <= '0;
      end else begin
         if (state == LS_IDLE && ex_ls_valid)
            bundle_q <= in_b;
         if (state != LS_OUT && state_nxt == LS_OUT)
            msg_q <= msg_d;
      end
   end

   // Request signals come straight from the latched bundle, so they are
   // stable for the whole REQ residency.
   assign in_req        = (state == LS_REQ) & ~rst;
   assign ex_ls_ready   = (state == LS_IDLE) & ~rst;
   assign dm_req        = in_req;
   assign dm_we         = in_req & is_store;
   assign dm_addr       = in_req ? cur_b.alu_res : '0;
   assign dm_wdata      = (in_req & is_store) ? al_wdata : '0;
   assign dm_wmask      = (in_req & is_store) ? al_mask : 8'h00;
   assign ls_wb_valid   = (state == LS_OUT) & ~rst;
   assign LS_WB_message = msg_q;

endmodule
